debug_dump_seq: RTL and testbench

DEBUG_DUMP_SEQ -- requirements
Module: debug_dump_seq

---
 rtl/debug_dump_seq.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_debug_dump_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_seq.sv
`default_nettype none
// ============================================================================
// debug_dump_seq : streams PC, cycle count, registers and memory as UART bytes
// Revision 1.0
// ============================================================================
module debug_dump_seq #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int N_REGS      = 32,
  parameter int NB_MEM_ADDR = 5,
  parameter int N_MEM_WORDS = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_dirty_only,
  input  logic [NB_DATA-1:0]     i_pc,
  input  logic [NB_DATA-1:0]     i_cycles,
  input  logic [NB_DATA-1:0]     i_reg_data,
  input  logic [NB_DATA-1:0]     i_mem_data,
  input  logic                   i_mem_dirty,
  input  logic                   i_tx_done,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  output logic                   o_reg_rd_en,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  output logic                   o_mem_rd_en,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int NB_BYTES = NB_DATA / 8;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_BCNT-1:0]     LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
  localparam logic [NB_REG_ADDR-1:0] LAST_REG  = NB_REG_ADDR'(N_REGS - 1);
  localparam logic [NB_MEM_ADDR-1:0] LAST_MEM  = NB_MEM_ADDR'(N_MEM_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SEND      = 4'd1,
    REG_RD    = 4'd2,
    REG_CAP   = 4'd3,
    MEM_RD    = 4'd4,
    MEM_CAP   = 4'd5,
    ADDR_SEND = 4'd6,
    TERM      = 4'd7,
    DONE      = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    SEC_PC  = 2'd0,
    SEC_CYC = 2'd1,
    SEC_REG = 2'd2,
    SEC_MEM = 2'd3
  } sec_t;

  state_t                 state_q, state_d;
  sec_t                   sec_q, sec_d;
  logic [NB_DATA-1:0]     word_q, word_d;
  logic [NB_BCNT-1:0]     bytes_left_q, bytes_left_d;
  logic [NB_DATA-1:0]     cycles_q, cycles_d;
  logic                   dirty_only_q, dirty_only_d;
  logic                   in_flight_q, in_flight_d;
  logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
  logic                   reg_rd_en_q, reg_rd_en_d;
  logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
  logic                   mem_rd_en_q, mem_rd_en_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   tx_ack;
  logic                   load_word;
  logic [NB_DATA-1:0]     load_val;
  logic                   send_byte;
  logic [7:0]             byte_val;
  logic                   end_mem;

  always_comb begin
    state_d      = state_q;
    sec_d        = sec_q;
    word_d       = word_q;
    bytes_left_d = bytes_left_q;
    cycles_d     = cycles_q;
    dirty_only_d = dirty_only_q;
    in_flight_d  = in_flight_q;
    reg_addr_d   = reg_addr_q;
    reg_rd_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_rd_en_d  = 1'b0;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    done_d       = 1'b0;
    load_word    = 1'b0;
    load_val     = '0;
    send_byte    = 1'b0;
    byte_val     = 8'h00;
    end_mem      = 1'b0;

    // A done strobe only counts while a byte is outstanding
    tx_ack = in_flight_q & i_tx_done;
    if (tx_ack) begin
      in_flight_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          cycles_d     = i_cycles;
          dirty_only_d = i_dirty_only;
          sec_d        = SEC_PC;
          load_word    = 1'b1;
          load_val     = i_pc;
        end
      end
      SEND: begin
        if (tx_ack) begin
          if (bytes_left_q != '0) begin
            send_byte    = 1'b1;
            byte_val     = word_q[NB_DATA-1 -: 8];
            word_d       = word_q << 8;
            bytes_left_d = bytes_left_q - NB_BCNT'(1);
          end else begin
            case (sec_q)
              SEC_PC: begin
                sec_d     = SEC_CYC;
                load_word = 1'b1;
                load_val  = cycles_q;
              end
              SEC_CYC: begin
                sec_d       = SEC_REG;
                state_d     = REG_RD;
                reg_addr_d  = '0;
                reg_rd_en_d = 1'b1;
              end
              SEC_REG: begin
                if (reg_addr_q == LAST_REG) begin
                  reg_addr_d  = '0;
                  sec_d       = SEC_MEM;
                  state_d     = MEM_RD;
                  mem_addr_d  = '0;
                  mem_rd_en_d = 1'b1;
                end else begin
                  reg_addr_d  = reg_addr_q + NB_REG_ADDR'(1);
                  state_d     = REG_RD;
                  reg_rd_en_d = 1'b1;
                end
              end
              SEC_MEM: begin
                if (mem_addr_q == LAST_MEM) begin
                  mem_addr_d = '0;
                  end_mem    = 1'b1;
                end else begin
                  mem_addr_d  = mem_addr_q + NB_MEM_ADDR'(1);
                  state_d     = MEM_RD;
                  mem_rd_en_d = 1'b1;
                end
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
      REG_RD: state_d = REG_CAP;
      REG_CAP: begin
        load_word = 1'b1;
        load_val  = i_reg_data;
      end
      MEM_RD: state_d = MEM_CAP;
      MEM_CAP: begin
        if (!dirty_only_q) begin
          load_word = 1'b1;
          load_val  = i_mem_data;
        end else if (i_mem_dirty) begin
          // Hold the raw word while its address tag goes out first
          word_d    = i_mem_data;
          state_d   = ADDR_SEND;
          send_byte = 1'b1;
          byte_val  = 8'(mem_addr_q);
        end else if (mem_addr_q == LAST_MEM) begin
          mem_addr_d = '0;
          end_mem    = 1'b1;
        end else begin
          mem_addr_d  = mem_addr_q + NB_MEM_ADDR'(1);
          state_d     = MEM_RD;
          mem_rd_en_d = 1'b1;
        end
      end
      ADDR_SEND: begin
        if (tx_ack) begin
          load_word = 1'b1;
          load_val  = word_q;
        end
      end
      TERM: begin
        if (tx_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (end_mem) begin
      if (dirty_only_q) begin
        state_d   = TERM;
        send_byte = 1'b1;
        byte_val  = 8'hFF;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end

    if (load_word) begin
      state_d      = SEND;
      send_byte    = 1'b1;
      byte_val     = load_val[NB_DATA-1 -: 8];
      word_d       = load_val << 8;
      bytes_left_d = LAST_BYTE;
    end

    if (send_byte) begin
      tx_start_d  = 1'b1;
      tx_data_d   = byte_val;
      in_flight_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      sec_q        <= SEC_PC;
      word_q       <= '0;
      bytes_left_q <= '0;
      cycles_q     <= '0;
      dirty_only_q <= 1'b0;
      in_flight_q  <= 1'b0;
      reg_addr_q   <= '0;
      reg_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_en_q  <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      word_q       <= word_d;
      bytes_left_q <= bytes_left_d;
      cycles_q     <= cycles_d;
      dirty_only_q <= dirty_only_d;
      in_flight_q  <= in_flight_d;
      reg_addr_q   <= reg_addr_d;
      reg_rd_en_q  <= reg_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_en_q  <= mem_rd_en_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_reg_addr  = reg_addr_q;
  assign o_reg_rd_en = reg_rd_en_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_rd_en = mem_rd_en_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_dump_seq.sv
`default_nettype none
// ============================================================================
// tb_debug_dump_seq : directed byte-stream bench for debug_dump_seq
// Revision 1.0
// ============================================================================
module tb_debug_dump_seq;

  localparam int NB_DATA     = 32;
  localparam int NB_REG_ADDR = 5;
  localparam int N_REGS      = 2;
  localparam int NB_MEM_ADDR = 5;
  localparam int N_MEM_WORDS = 4;
  localparam int BUDGET      = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   main_start, spam_start, start;
  logic                   dirty_only;
  logic [NB_DATA-1:0]     pc, cycles, reg_data, mem_data;
  logic                   mem_dirty;
  logic                   model_done, inject_done, tx_done;
  logic [NB_REG_ADDR-1:0] reg_addr;
  logic                   reg_rd_en;
  logic [NB_MEM_ADDR-1:0] mem_addr;
  logic                   mem_rd_en;
  logic [7:0]             tx_data;
  logic                   tx_start, busy, done;

  assign start   = main_start | spam_start;
  assign tx_done = model_done | inject_done;

  debug_dump_seq #(
    .NB_DATA    (NB_DATA),
    .NB_REG_ADDR(NB_REG_ADDR),
    .N_REGS     (N_REGS),
    .NB_MEM_ADDR(NB_MEM_ADDR),
    .N_MEM_WORDS(N_MEM_WORDS)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_dirty_only(dirty_only),
    .i_pc        (pc),
    .i_cycles    (cycles),
    .i_reg_data  (reg_data),
    .i_mem_data  (mem_data),
    .i_mem_dirty (mem_dirty),
    .i_tx_done   (tx_done),
    .o_reg_addr  (reg_addr),
    .o_reg_rd_en (reg_rd_en),
    .o_mem_addr  (mem_addr),
    .o_mem_rd_en (mem_rd_en),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_busy      (busy),
    .o_done      (done)
  );

  typedef struct {
    logic        dirty;
    logic [3:0]  mask;
    logic [31:0] pc;
    logic [31:0] cyc;
    int          lat_mode;
    int          exp_len;
  } rec_t;

  rec_t       tbl [6];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int         checks, errors;
  int         start_cnt, done_cnt, stable_err, overlap_err, addr_err;
  int         lat_mode;
  logic [3:0] mask;
  bit         spam_en;

  function automatic logic [31:0] reg_val(input logic [NB_REG_ADDR-1:0] k);
    return (k == 0) ? 32'h11223344 : 32'h55667788;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endfunction

  function automatic void build_exp(input rec_t r);
    logic [31:0] m;
    exp_q.delete();
    push_word(r.pc);
    push_word(r.cyc);
    push_word(32'h11223344);
    push_word(32'h55667788);
    for (int i = 0; i < 4; i++) begin
      m = 32'hA0 + i;
      if (!r.dirty) push_word(m);
      else if (r.mask[i]) begin
        exp_q.push_back(8'(i));
        push_word(m);
      end
    end
    if (r.dirty) exp_q.push_back(8'hFF);
  endfunction

  // UART TX stand-in: records bytes, answers each start after the chosen latency
  initial begin : tx_model
    int cnt;
    logic [7:0] cur;
    cnt = 0;
    cur = 8'h00;
    model_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      model_done = 1'b0;
      if (done) done_cnt++;
      if (rst) cnt = 0;
      else if (cnt > 0) begin
        if (tx_data !== cur) stable_err++;
        if (tx_start) overlap_err++;
        cnt--;
        if (cnt == 0) model_done = 1'b1;
      end else if (tx_start) begin
        got.push_back(tx_data);
        cur = tx_data;
        start_cnt++;
        cnt = (lat_mode == 0) ? 3 : ((start_cnt % 2 == 1) ? 1 : 100);
      end
    end
  end

  // Synchronous register file / memory: data valid only the cycle after the strobe
  initial begin : mem_model
    bit reg_pend, mem_pend;
    logic [NB_REG_ADDR-1:0] ra;
    logic [NB_MEM_ADDR-1:0] ma;
    reg_pend = 0; mem_pend = 0; ra = '0; ma = '0;
    reg_data = 32'hBAD0BAD0; mem_data = 32'hBAD0BAD0; mem_dirty = 1'b1;
    forever begin
      @(posedge clk); #1;
      reg_data  = reg_pend ? reg_val(ra) : 32'hBAD0BAD0;
      mem_data  = mem_pend ? (32'hA0 + 32'(ma)) : 32'hBAD0BAD0;
      mem_dirty = mem_pend ? ((ma < 4) ? mask[ma[1:0]] : 1'b0) : 1'b1;
      reg_pend  = reg_rd_en;
      mem_pend  = mem_rd_en;
      ra = reg_addr;
      ma = mem_addr;
      if (reg_rd_en && reg_addr >= N_REGS) addr_err++;
      if (mem_rd_en && mem_addr >= N_MEM_WORDS) addr_err++;
    end
  end

  initial begin : spam
    spam_start = 1'b0;
    forever begin
      @(negedge clk);
      spam_start = spam_en && busy && (done || ($urandom_range(0, 2) == 0));
    end
  end

  task automatic run_frame(input rec_t r, input string tag);
    int budget, bad;
    dirty_only = r.dirty; mask = r.mask; pc = r.pc; cycles = r.cyc; lat_mode = r.lat_mode;
    build_exp(r);
    got.delete();
    done_cnt = 0; start_cnt = 0; stable_err = 0; overlap_err = 0; addr_err = 0;
    main_start = 1'b1;
    @(negedge clk);
    main_start = 1'b0;
    // Inputs scrambled after the start: the dump must use latched values
    pc = 32'hFFFFFFFF; cycles = 32'hFFFFFFFF; dirty_only = ~r.dirty;
    budget = 0;
    while (done_cnt == 0 && budget < BUDGET) begin
      @(negedge clk);
      budget++;
    end
    check({tag, " done_timeout"}, 64'(budget < BUDGET), 64'd1);
    repeat (4) @(negedge clk);
    check({tag, " byte_count"}, 64'(got.size()), 64'(r.exp_len));
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad < 0 && (i >= got.size() || got[i] !== exp_q[i])) bad = i;
    check({tag, " first_bad_byte_index"}, 64'(bad), 64'(-1));
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " data_stable_and_single"}, 64'(stable_err + overlap_err), 64'd0);
    check({tag, " addr_range"}, 64'(addr_err), 64'd0);
  endtask

  initial begin : main
    int budget;
    checks = 0; errors = 0;
    start_cnt = 0; done_cnt = 0; stable_err = 0; overlap_err = 0; addr_err = 0;
    rst = 1'b1; main_start = 1'b0; inject_done = 1'b0; spam_en = 1'b0;
    dirty_only = 1'b0; pc = '0; cycles = '0; lat_mode = 0; mask = 4'h0;

    tbl[0] = '{1'b0, 4'b0000, 32'h00000010, 32'h00000005, 0, 32};
    tbl[1] = '{1'b1, 4'b1010, 32'h00000010, 32'h00000005, 0, 27};
    tbl[2] = '{1'b1, 4'b0000, 32'h00000010, 32'h00000005, 0, 17};
    tbl[3] = '{1'b0, 4'b0000, 32'h00000010, 32'h00000005, 1, 32};
    tbl[4] = '{1'b1, 4'b1111, 32'hDEADBEEF, 32'h12345678, 0, 37};
    tbl[5] = '{1'b1, 4'b1001, 32'hCAFEF00D, 32'h00000100, 1, 27};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({reg_addr, reg_rd_en, mem_addr, mem_rd_en, tx_data, tx_start, busy, done}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_tx_done_no_start", 64'(start_cnt), 64'd0);
    check("idle_tx_done_not_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Reset right after the fifth byte starts
    dirty_only = 1'b0; mask = 4'h0; pc = 32'h10; cycles = 32'h5; lat_mode = 0;
    got.delete(); start_cnt = 0; done_cnt = 0;
    main_start = 1'b1;
    @(negedge clk);
    main_start = 1'b0;
    budget = 0;
    while (start_cnt < 5 && budget < BUDGET) begin
      @(negedge clk);
      budget++;
    end
    check("midreset reach_5th_start", 64'(budget < BUDGET), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset outputs_cleared",
          64'({reg_addr, reg_rd_en, mem_addr, mem_rd_en, tx_data, tx_start, busy, done}), 64'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midreset no_further_start", 64'(start_cnt), 64'd5);
    check("midreset no_done", 64'(done_cnt), 64'd0);
    run_frame(tbl[0], "restart");

    // Start requests while busy and in DONE
    spam_en = 1'b1;
    run_frame(tbl[0], "start_while_busy");
    spam_en = 1'b0;
    repeat (20) @(negedge clk);
    check("start_while_busy no_extra_frame", 64'(start_cnt), 64'd32);
    check("start_while_busy no_extra_done", 64'(done_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
